muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage, beside the ALU. Takes the same forwarded
//   operands (In1/In2) and owns the HI/LO registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
//   hi/lo feed the EX result mux; busy drives the hazard unit, which stalls later HI/LO users.
// PARAMETERS
//   MUL_CYCLES  5   cycles from accepted start to HI/LO update for multiply (>=1)
//   DIV_CYCLES  32  cycles for divide; one restoring quotient bit per cycle (fixed at 32)
// PORTS
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   launch operation md_op this cycle
//   md_op    in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   In1      in   32  rs operand (multiplicand / dividend)
//   In2      in   32  rt operand (multiplier / divisor)
//   hi_we    in   1   MTHI: write wdata to HI
//   lo_we    in   1   MTLO: write wdata to LO
//   wdata    in   32  MTHI/MTLO data
//   hi       out  32  HI register
//   lo       out  32  LO register
//   busy     out  1   operation in flight
// BEHAVIOUR
//   Reset (async, rst_n=0): hi=0, lo=0, busy=0, state IDLE, counter 0. Reset mid-operation
//     abandons it; HI/LO stay 0 and the result is never written.
//   States: IDLE -> MUL (start & md_op[1]=0) | DIV (start & md_op[1]=1); MUL/DIV -> IDLE at count end.
//   Accept: start sampled at edge N in IDLE; operands and op latched at N; busy=1 from N.
//   Multiply: 64-bit product (signed for MULT, unsigned for MULTU) -> {hi,lo} at edge
//     N+MUL_CYCLES; busy falls at that same edge. Product computed from latched operands only.
//   Divide: restoring, latched |operands| for DIV; lo=quotient, hi=remainder at edge N+32.
//     DIV signs: quotient truncates toward zero; remainder takes dividend sign.
//     Divide by zero: lo=32'hFFFFFFFF, hi=dividend (no exception); full 32 cycles still taken.
//     Overflow 32'h80000000 / 32'hFFFFFFFF (DIV): lo=32'h80000000, hi=0.
//   HI and LO update atomically in one edge; never partially visible.
//   start while busy: ignored (no relaunch, no corruption). Hazard unit must stall instead.
//   hi_we/lo_we in IDLE: written at next edge; hi_we and lo_we together write both.
//   hi_we/lo_we while busy: ignored.
//   start with hi_we/lo_we in the same IDLE cycle: start wins; the writes are dropped.
//   Operand changes on In1/In2 after acceptance have no effect.
//   Back-to-back: a start in the cycle after busy falls is accepted normally (no dead cycle).
// STRUCTURE
//   Shared package/header: md_op encodings (MD_MULT..MD_DIVU), state encodings, DIV_CYCLES.
//   One sub-module: muldiv_divider (32-step restoring core with start/done and unsigned
//     quotient/remainder out). Sign fix-up, multiply, counter, FSM and HI/LO live in the top.
// TESTING
//   MULT 32'hFFFFFFFE x 32'h00000003 -> {hi,lo}=FFFFFFFF_FFFFFFFA after 5 cycles; busy high 5.
//   MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//   DIV 32'hFFFFFFF9 (-7) / 2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1) after 32 cycles;
//     DIVU 7/0 -> lo=FFFFFFFF, hi=00000007.
//   DIV 32'h80000000 / 32'hFFFFFFFF -> lo=80000000, hi=0, no X.
//   start plus MTHI 32'h1234 at cycle 3 of a DIV -> both ignored; the DIV result is intact;
//     MTLO 32'hABCD when idle -> lo=ABCD next edge, hi unchanged.
//   rst_n low at cycle 10 of a DIV -> busy=0, hi=lo=0 at once; a fresh MULTU 3x4 afterwards
//     -> lo=12 after 5 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation and
// state encodings, cycle counts and small two's-complement helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } md_state_e;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 8;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Magnitude of v when it is to be treated as signed; raw value otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return neg_if(v, sgn & v[31]);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// 32-step unsigned restoring divider. quotient_o/remainder_o are the values
// produced by the current step and are final in the cycle done_o is high.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

  logic        active_q, active_d;
  logic [4:0]  step_q, step_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  // quo_q starts as the dividend and shifts out its MSB each step while the
  // quotient bits shift in from the bottom.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    ge       = (shifted >= {1'b0, dvs_q});
    // When ge holds the true difference is below the divisor, so 32 bits suffice.
    diff     = shifted[31:0] - dvs_q;
    rem_step = ge ? diff : shifted[31:0];
    quo_step = {quo_q[30:0], ge};
  end

  always_comb begin
    active_d = active_q;
    step_d   = step_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    if (start_i) begin
      active_d = 1'b1;
      step_d   = '0;
      rem_d    = '0;
      quo_d    = dividend_i;
      dvs_d    = divisor_i;
    end else if (active_q) begin
      rem_d  = rem_step;
      quo_d  = quo_step;
      step_d = step_q + 5'd1;
      if (step_q == LAST_STEP) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      step_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      step_q   <= step_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
    end
  end

  assign done_o      = active_q && (step_q == LAST_STEP);
  assign quotient_o  = quo_step;
  assign remainder_o = rem_step;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Multiplies complete after
// MUL_CYCLES, divides after 32; HI/LO are written together in one edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MUL_END = CNT_W'(MUL_CYCLES);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;

  logic        in_signed_div;
  logic [31:0] dvd_abs, dvs_abs;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;
  logic        mul_signed, div_signed;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] res_lo, res_hi;

  // The divider latches magnitudes straight from the operand bus on accept.
  assign in_signed_div = (md_op == MD_DIV);
  assign dvd_abs       = abs32(In1, in_signed_div);
  assign dvs_abs       = abs32(In2, in_signed_div);

  muldiv_divider u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (dvd_abs),
    .divisor_i   (dvs_abs),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    mul_signed = (op_q == MD_MULT);
    ext_a      = {{32{mul_signed & a_q[31]}}, a_q};
    ext_b      = {{32{mul_signed & b_q[31]}}, b_q};
    prod       = ext_a * ext_b;
  end

  // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
  always_comb begin
    div_signed = (op_q == MD_DIV);
    res_lo     = div_quo;
    res_hi     = div_rem;
    if (b_q == 32'd0) begin
      res_lo = 32'hFFFF_FFFF;
      res_hi = a_q;
    end else if (div_signed) begin
      res_lo = neg_if(div_quo, a_q[31] ^ b_q[31]);
      res_hi = neg_if(div_rem, a_q[31]);
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = md_op_e'(md_op);
          a_d       = In1;
          b_d       = In2;
          cnt_d     = CNT_W'(1);
          div_start = md_op[1];
          state_d   = md_op[1] ? ST_DIV : ST_MUL;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_MUL: begin
        if (cnt_q == MUL_END) begin
          {hi_d, lo_d} = prod;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_done) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);

endmodule
